// File: rtl/pipeline_hazard_controller_if.sv
// Purpose: groups the hazard-controller decode inputs, control outputs and counters.
// Latency: none, signal bundle only.
// Backpressure: none, controller outputs are level signals sampled by the pipeline.
interface pipeline_hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic             idie_mem_read;
  logic [4:0]       idie_rt;
  logic             branch_taken;
  logic             dmem_busy;
  logic             cnt_clear;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  // Pipeline side: supplies hazard information, consumes the stall/flush controls.
  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idie_mem_read, idie_rt,
           branch_taken, dmem_busy, cnt_clear,
    input  pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze,
           stall_cnt, flush_cnt, freeze_cnt
  );

  // Controller side.
  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idie_mem_read, idie_rt,
           branch_taken, dmem_busy, cnt_clear,
    output pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze,
           stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Purpose: ID-stage stall/flush/freeze sequencer for the 5-stage MIPS pipeline, with event counters.
// Latency: controls are combinational from inputs+state (same edge); state/counters update next edge.
// Backpressure: dmem_busy freezes the whole pipeline and pauses any pending load-use bubbles.
module pipeline_hazard_controller #(
  parameter int LOAD_STALL_CYCLES = 1,  // legal range 1..15, remain counter is 4 bits
  parameter int CNT_W             = 16
) (
  input logic                         clk,
  input logic                         reset,
  pipeline_hazard_controller_if.slave bus
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_LSTALL = 1'b1
  } state_t;

  // The hazard cycle itself is the first bubble, so LSTALL covers the rest.
  localparam logic [3:0]       LP_REMAIN_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam bit               LP_MULTI       = (LOAD_STALL_CYCLES > 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] LP_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_remain;
  logic [3:0]       w_remain_nxt;
  logic             w_hz;
  logic             w_pc_hold;
  logic             w_ifid_hold;
  logic             w_ifid_flush;
  logic             w_idex_bubble;
  logic             w_pipe_freeze;
  logic             w_inc_stall;
  logic             w_inc_flush;
  logic             w_inc_freeze;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_freeze_cnt;

  // Register $0 is hardwired, so a load into it never creates a dependency.
  assign w_hz = bus.idie_mem_read & (bus.idie_rt != 5'd0) &
                ((bus.idie_rt == bus.ifid_rs) |
                 (bus.ifid_uses_rt & (bus.idie_rt == bus.ifid_rt)));

  // State and remaining-bubble register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_remain <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_remain <= w_remain_nxt;
    end
  end

  // Priority decode: memory freeze, then branch flush, then pending bubbles, then new hazard.
  always_comb begin
    w_state_nxt   = r_state;
    w_remain_nxt  = r_remain;
    w_pc_hold     = 1'b0;
    w_ifid_hold   = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_pipe_freeze = 1'b0;
    w_inc_stall   = 1'b0;
    w_inc_flush   = 1'b0;
    w_inc_freeze  = 1'b0;
    if (bus.dmem_busy) begin
      // Everything holds, including the bubble countdown.
      w_pipe_freeze = 1'b1;
      w_pc_hold     = 1'b1;
      w_ifid_hold   = 1'b1;
      w_inc_freeze  = 1'b1;
    end else if (bus.branch_taken) begin
      // The stalled instruction is on the wrong path, so pending bubbles are dropped.
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_inc_flush   = 1'b1;
      w_state_nxt   = ST_RUN;
      w_remain_nxt  = 4'd0;
    end else if (r_state == ST_LSTALL) begin
      w_pc_hold     = 1'b1;
      w_ifid_hold   = 1'b1;
      w_idex_bubble = 1'b1;
      w_inc_stall   = 1'b1;
      if (r_remain == 4'd1) begin
        w_state_nxt  = ST_RUN;
        w_remain_nxt = 4'd0;
      end else begin
        w_remain_nxt = r_remain - 4'd1;
      end
    end else if (w_hz) begin
      w_pc_hold     = 1'b1;
      w_ifid_hold   = 1'b1;
      w_idex_bubble = 1'b1;
      w_inc_stall   = 1'b1;
      if (LP_MULTI) begin
        w_state_nxt  = ST_LSTALL;
        w_remain_nxt = LP_REMAIN_INIT;
      end
    end
  end

  // Saturating event counters; clear overrides any increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else if (bus.cnt_clear) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (w_inc_stall && (r_stall_cnt != LP_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
      end
      if (w_inc_flush && (r_flush_cnt != LP_CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + LP_CNT_ONE;
      end
      if (w_inc_freeze && (r_freeze_cnt != LP_CNT_MAX)) begin
        r_freeze_cnt <= r_freeze_cnt + LP_CNT_ONE;
      end
    end
  end

  // Controls are forced low while reset is held so the pipeline sees no stale hold/flush.
  assign bus.pc_hold     = w_pc_hold     & ~reset;
  assign bus.ifid_hold   = w_ifid_hold   & ~reset;
  assign bus.ifid_flush  = w_ifid_flush  & ~reset;
  assign bus.idex_bubble = w_idex_bubble & ~reset;
  assign bus.pipe_freeze = w_pipe_freeze & ~reset;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;
  assign bus.freeze_cnt  = r_freeze_cnt;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Purpose: directed checks of the hazard controller, N=1/CNT_W=16 (dut_a) and N=3/CNT_W=4 (dut_b).
// Latency: inputs change 1 time unit after a rising edge, controls sampled 2 units later.
// Backpressure: not applicable, bench drives dmem_busy directly.
module tb_pipeline_hazard_controller;

  // Control vector encoding: {pc_hold, ifid_hold, ifid_flush, idex_bubble, pipe_freeze}
  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_STALL  = 5'b11010;
  localparam logic [4:0] C_FLUSH  = 5'b00110;
  localparam logic [4:0] C_FREEZE = 5'b11001;

  typedef struct {
    string      nm;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] idie_rt;
    logic       br;
    logic       busy;
    logic [4:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] t_rs = '0;
  logic [4:0] t_rt = '0;
  logic       t_uses_rt = 1'b0;
  logic       t_mem_read = 1'b0;
  logic [4:0] t_idie_rt = '0;
  logic       t_br = 1'b0;
  logic       t_busy = 1'b0;
  logic       t_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  vec_t tbl [12];

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_W(16)) ifa ();
  pipeline_hazard_controller_if #(.CNT_W(4))  ifb ();

  assign ifa.ifid_rs       = t_rs;
  assign ifa.ifid_rt       = t_rt;
  assign ifa.ifid_uses_rt  = t_uses_rt;
  assign ifa.idie_mem_read = t_mem_read;
  assign ifa.idie_rt       = t_idie_rt;
  assign ifa.branch_taken  = t_br;
  assign ifa.dmem_busy     = t_busy;
  assign ifa.cnt_clear     = t_clr;
  assign ifb.ifid_rs       = t_rs;
  assign ifb.ifid_rt       = t_rt;
  assign ifb.ifid_uses_rt  = t_uses_rt;
  assign ifb.idie_mem_read = t_mem_read;
  assign ifb.idie_rt       = t_idie_rt;
  assign ifb.branch_taken  = t_br;
  assign ifb.dmem_busy     = t_busy;
  assign ifb.cnt_clear     = t_clr;

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  wire [4:0] ctl_a = {ifa.pc_hold, ifa.ifid_hold, ifa.ifid_flush, ifa.idex_bubble, ifa.pipe_freeze};
  wire [4:0] ctl_b = {ifb.pc_hold, ifb.ifid_hold, ifb.ifid_flush, ifb.idex_bubble, ifb.pipe_freeze};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                     input logic mr, input logic [4:0] irt, input logic br, input logic busy);
    t_rs       = rs;
    t_rt       = rt;
    t_uses_rt  = uses;
    t_mem_read = mr;
    t_idie_rt  = irt;
    t_br       = br;
    t_busy     = busy;
  endtask

  // lw $2 in ID/EX with add $3,$2,$4 in IF/ID, and the same pair after the load has moved on.
  task automatic hz_on();  drv(5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0); endtask
  task automatic hz_off(); drv(5'd2, 5'd4, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0); endtask

  // Apply inputs, sample controls mid-cycle, then advance past the edge.
  task automatic step_b(input string nm, input logic [4:0] exp);
    #2;
    chk(nm, 32'(ctl_b), 32'(exp));
    cyc();
  endtask

  task automatic clear_cnt();
    drv('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    t_clr = 1'b1;
    cyc();
    t_clr = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{"idle",          5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_NONE};
    tbl[1]  = '{"lw_add_rs",     5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, C_STALL};
    tbl[2]  = '{"add_leaves",    5'd2, 5'd4, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, C_NONE};
    tbl[3]  = '{"rt_zero",       5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, C_NONE};
    tbl[4]  = '{"rt_only_nouse", 5'd1, 5'd2, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, C_NONE};
    tbl[5]  = '{"rt_only_use",   5'd1, 5'd2, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, C_STALL};
    tbl[6]  = '{"match_no_load", 5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, C_NONE};
    tbl[7]  = '{"branch",        5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_FLUSH};
    tbl[8]  = '{"hz_and_branch", 5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, C_FLUSH};
    tbl[9]  = '{"busy",          5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, C_FREEZE};
    tbl[10] = '{"busy_all",      5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, C_FREEZE};
    tbl[11] = '{"idle_end",      5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, C_NONE};

    // Reset state: hazard presented while reset is held must give quiet outputs.
    hz_on();
    #2;
    chk("rst_ctl_a", 32'(ctl_a), 32'(C_NONE));
    chk("rst_ctl_b", 32'(ctl_b), 32'(C_NONE));
    chk("rst_stall_a", 32'(ifa.stall_cnt), 32'd0);
    chk("rst_freeze_b", 32'(ifb.freeze_cnt), 32'd0);
    cyc();
    drv('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();

    // Single-bubble controller: every vector is independent since it never leaves RUN.
    for (int i = 0; i < 12; i++) begin
      drv(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].mem_read, tbl[i].idie_rt, tbl[i].br, tbl[i].busy);
      #2;
      chk({"tbl_", tbl[i].nm}, 32'(ctl_a), 32'(tbl[i].exp));
      cyc();
    end
    chk("tbl_stall_cnt", 32'(ifa.stall_cnt), 32'd2);
    chk("tbl_flush_cnt", 32'(ifa.flush_cnt), 32'd2);
    chk("tbl_freeze_cnt", 32'(ifa.freeze_cnt), 32'd2);

    // Restart dut_b cleanly after it tracked the table inputs.
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // N=3 load-use: three bubbles, the last two driven by state alone.
    hz_on();  step_b("n3_b1", C_STALL);
    hz_off(); step_b("n3_b2", C_STALL);
    step_b("n3_b3", C_STALL);
    step_b("n3_run", C_NONE);
    chk("n3_stall_cnt", 32'(ifb.stall_cnt), 32'd3);
    drv(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0); step_b("n3_rt_zero", C_NONE);
    drv(5'd1, 5'd2, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0); step_b("n3_rt_nouse", C_NONE);
    chk("n3_stall_cnt_hold", 32'(ifb.stall_cnt), 32'd3);

    // Branch during the second bubble cancels the third.
    clear_cnt();
    chk("clr_stall", 32'(ifb.stall_cnt), 32'd0);
    hz_on();  step_b("bl_b1", C_STALL);
    hz_off(); step_b("bl_b2", C_STALL);
    t_br = 1'b1; step_b("bl_flush", C_FLUSH);
    t_br = 1'b0; step_b("bl_run", C_NONE);
    chk("bl_stall_cnt", 32'(ifb.stall_cnt), 32'd2);
    chk("bl_flush_cnt", 32'(ifb.flush_cnt), 32'd1);
    // Branch right after the hazard cycle, with two bubbles still pending.
    hz_on();  step_b("be_b1", C_STALL);
    hz_off(); t_br = 1'b1; step_b("be_flush", C_FLUSH);
    t_br = 1'b0; step_b("be_run", C_NONE);
    // Hazard and branch together: no stall entered.
    hz_on(); t_br = 1'b1; step_b("hb_flush", C_FLUSH);
    hz_off(); step_b("hb_run", C_NONE);
    chk("hb_stall_cnt", 32'(ifb.stall_cnt), 32'd3);
    chk("hb_flush_cnt", 32'(ifb.flush_cnt), 32'd3);

    // Memory wait in the middle of the bubble train pauses the countdown.
    clear_cnt();
    hz_on();  step_b("mw_b1", C_STALL);
    hz_off(); step_b("mw_b2", C_STALL);
    t_busy = 1'b1;
    for (int i = 0; i < 4; i++) step_b($sformatf("mw_freeze%0d", i), C_FREEZE);
    t_busy = 1'b0; step_b("mw_b3", C_STALL);
    step_b("mw_run", C_NONE);
    chk("mw_stall_cnt", 32'(ifb.stall_cnt), 32'd3);
    chk("mw_freeze_cnt", 32'(ifb.freeze_cnt), 32'd4);

    // 4-bit counter saturation, then clear wins over a concurrent increment.
    clear_cnt();
    t_busy = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_freeze_cnt", 32'(ifb.freeze_cnt), 32'd15);
    t_clr = 1'b1;
    cyc();
    t_clr = 1'b0;
    chk("sat_clr_freeze", 32'(ifb.freeze_cnt), 32'd0);
    t_busy = 1'b0;

    // Reset mid-LSTALL: outputs drop immediately, RUN after release.
    hz_on();  step_b("rs_b1", C_STALL);
    hz_off();
    #2;
    chk("rs_b2", 32'(ctl_b), 32'(C_STALL));
    reset = 1'b1;
    #1;
    chk("rs_ctl_now", 32'(ctl_b), 32'(C_NONE));
    chk("rs_stall_cnt", 32'(ifb.stall_cnt), 32'd0);
    cyc();
    reset = 1'b0;
    step_b("rs_run", C_NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
